// File: rtl/rv_pipeline_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV64 core: stage valids, stalls, redirects, forwarding.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module rv_pipeline_ctrl #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              ex_busy_i,
  input  logic              ex_br_taken_i,
  input  logic [XLEN-1:0]   ex_br_target_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regwrite_i,
  output logic              pc_we_o,
  output logic              pc_sel_o,
  output logic [XLEN-1:0]   pc_target_o,
  output logic              ifid_we_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              v_id_o,
  output logic              v_ex_o,
  output logic              v_mem_o,
  output logic              v_wb_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  cnt_cycle_o,
  output logic [CNT_W-1:0]  cnt_retire_o,
  output logic [CNT_W-1:0]  cnt_stall_o,
  output logic [CNT_W-1:0]  cnt_flush_o
);

  logic v_id_q, v_ex_q, v_mem_q, v_wb_q;
  logic v_id_d, v_ex_d, v_mem_d, v_wb_d;
  logic redirect_s;
  logic loaduse_s;

  // MEM result is younger than WB writedata, so it wins a double match; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    if (v_mem_q && mem_regwrite_i && (mem_rd_i != {REG_AW{1'b0}}) && (mem_rd_i == src)) begin
      sel = 2'b10;
    end else if (v_wb_q && wb_regwrite_i && (wb_rd_i != {REG_AW{1'b0}}) && (wb_rd_i == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign redirect_s = v_ex_q & ex_br_taken_i & ~ex_busy_i;
  assign loaduse_s  = v_id_q & v_ex_q & ex_memread_i & (ex_rd_i != {REG_AW{1'b0}}) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // Control strobes and next stage-valids; priority busy > redirect > load-use > normal.
  always_comb begin
    pc_we_o        = 1'b0;
    pc_sel_o       = 1'b0;
    ifid_we_o      = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    fwd_a_o        = 2'b00;
    fwd_b_o        = 2'b00;
    v_id_d         = v_id_q;
    v_ex_d         = v_ex_q;
    v_mem_d        = v_mem_q;
    v_wb_d         = v_wb_q;
    if (reset_i) begin
      v_id_d  = 1'b0;
      v_ex_d  = 1'b0;
      v_mem_d = 1'b0;
      v_wb_d  = 1'b0;
    end else begin
      fwd_a_o = fwd_sel(ex_rs1_i);
      fwd_b_o = fwd_sel(ex_rs2_i);
      v_wb_d  = v_mem_q;
      if (ex_busy_i) begin
        exmem_bubble_o = 1'b1;
        v_mem_d        = 1'b0;
      end else if (redirect_s) begin
        // The branch itself carries on into MEM; the two younger slots are squashed.
        pc_we_o       = 1'b1;
        pc_sel_o      = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        v_id_d        = 1'b0;
        v_ex_d        = 1'b0;
        v_mem_d       = 1'b1;
      end else if (loaduse_s) begin
        idex_bubble_o = 1'b1;
        v_ex_d        = 1'b0;
        v_mem_d       = v_ex_q;
      end else begin
        pc_we_o   = 1'b1;
        ifid_we_o = 1'b1;
        v_id_d    = 1'b1;
        v_ex_d    = v_id_q;
        v_mem_d   = v_ex_q;
      end
    end
  end

  // Stage-valid registers.
  always_ff @(posedge clk_i) begin
    v_id_q  <= v_id_d;
    v_ex_q  <= v_ex_d;
    v_mem_q <= v_mem_d;
    v_wb_q  <= v_wb_d;
  end

  assign pc_target_o = reset_i ? {XLEN{1'b0}} : ex_br_target_i;
  assign v_id_o      = v_id_q  & ~reset_i;
  assign v_ex_o      = v_ex_q  & ~reset_i;
  assign v_mem_o     = v_mem_q & ~reset_i;
  assign v_wb_o      = v_wb_q  & ~reset_i;
  assign retire_o    = v_wb_q  & ~reset_i;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cnt_cycle_q, cnt_retire_q, cnt_stall_q, cnt_flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (c != {CNT_W{1'b1}})) begin
      r = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_cycle_q  <= {CNT_W{1'b0}};
      cnt_retire_q <= {CNT_W{1'b0}};
      cnt_stall_q  <= {CNT_W{1'b0}};
      cnt_flush_q  <= {CNT_W{1'b0}};
    end else begin
      cnt_cycle_q  <= sat_inc(cnt_cycle_q, 1'b1);
      cnt_retire_q <= sat_inc(cnt_retire_q, v_wb_q);
      cnt_stall_q  <= sat_inc(cnt_stall_q, ex_busy_i | loaduse_s);
      cnt_flush_q  <= sat_inc(cnt_flush_q, redirect_s);
    end
  end

  assign cnt_cycle_o  = reset_i ? {CNT_W{1'b0}} : cnt_cycle_q;
  assign cnt_retire_o = reset_i ? {CNT_W{1'b0}} : cnt_retire_q;
  assign cnt_stall_o  = reset_i ? {CNT_W{1'b0}} : cnt_stall_q;
  assign cnt_flush_o  = reset_i ? {CNT_W{1'b0}} : cnt_flush_q;
`else
  assign cnt_cycle_o  = {CNT_W{1'b0}};
  assign cnt_retire_o = {CNT_W{1'b0}};
  assign cnt_stall_o  = {CNT_W{1'b0}};
  assign cnt_flush_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv_pipeline_ctrl.sv
// Bench for rv_pipeline_ctrl: directed scenarios plus randomized cycles against an occupancy model.
module tb_rv_pipeline_ctrl;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;
  localparam longint CMAX = (64'd1 << CNT_W) - 64'd1;

  logic clk = 1'b0;
  logic reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_busy, ex_br_taken, mem_regwrite, wb_regwrite;
  logic [XLEN-1:0] ex_br_target;
  logic pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exmem_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic v_id, v_ex, v_mem, v_wb, retire;
  logic [XLEN-1:0] pc_target;
  logic [CNT_W-1:0] cnt_cycle, cnt_retire, cnt_stall, cnt_flush;
  logic [14:0] dut_ctrl;
  logic [4*CNT_W-1:0] dut_cnts;

  int vectors = 0;
  int miscompares = 0;

  // Model: occupancy of ID/EX/MEM/WB and event tallies.
  logic m_id = 1'b0, m_ex = 1'b0, m_mem = 1'b0, m_wb = 1'b0;
  longint m_cyc = 0, m_ret = 0, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  rv_pipeline_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
    .ex_busy_i(ex_busy), .ex_br_taken_i(ex_br_taken), .ex_br_target_i(ex_br_target),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .pc_we_o(pc_we), .pc_sel_o(pc_sel), .pc_target_o(pc_target), .ifid_we_o(ifid_we),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .exmem_bubble_o(exmem_bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .v_id_o(v_id), .v_ex_o(v_ex), .v_mem_o(v_mem), .v_wb_o(v_wb),
    .retire_o(retire), .cnt_cycle_o(cnt_cycle), .cnt_retire_o(cnt_retire),
    .cnt_stall_o(cnt_stall), .cnt_flush_o(cnt_flush)
  );

  assign dut_ctrl = {pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, exmem_bubble,
                     fwd_a, fwd_b, v_id, v_ex, v_mem, v_wb, retire};
  assign dut_cnts = {cnt_cycle, cnt_retire, cnt_stall, cnt_flush};

  // 3 = EX busy, 2 = branch redirect, 1 = load-use stall, 0 = advance.
  function automatic int mode();
    if (ex_busy) return 3;
    if (m_ex && ex_br_taken) return 2;
    if (m_id && m_ex && ex_memread && ex_rd != 0 &&
        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [REG_AW-1:0] src);
    if (src != 0 && m_mem && mem_regwrite && mem_rd == src) return 2'b10;
    if (src != 0 && m_wb && wb_regwrite && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [14:0] m_ctrl();
    int md;
    if (reset) return 15'd0;
    md = mode();
    return {(md == 0 || md == 2), (md == 2), (md == 0), (md == 2), (md == 1 || md == 2), (md == 3),
            m_fwd(ex_rs1), m_fwd(ex_rs2), m_id, m_ex, m_mem, m_wb, m_wb};
  endfunction

  function automatic logic [4*CNT_W-1:0] m_cnts();
`ifdef PERF_COUNTERS_EN
    if (reset) return '0;
    return {m_cyc[CNT_W-1:0], m_ret[CNT_W-1:0], m_stall[CNT_W-1:0], m_flush[CNT_W-1:0]};
`else
    return '0;
`endif
  endfunction

  task automatic model_update();
    int md;
    if (reset) begin
      {m_id, m_ex, m_mem, m_wb} = 4'b0000;
      m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0;
    end else begin
      md = mode();
      if (m_cyc < CMAX) m_cyc++;
      if (m_wb && m_ret < CMAX) m_ret++;
      if ((md == 1 || md == 3) && m_stall < CMAX) m_stall++;
      if (md == 2 && m_flush < CMAX) m_flush++;
      m_wb = m_mem;
      case (md)
        3: m_mem = 1'b0;
        2: begin m_mem = 1'b1; m_ex = 1'b0; m_id = 1'b0; end
        1: begin m_mem = m_ex; m_ex = 1'b0; end
        default: begin m_mem = m_ex; m_ex = m_id; m_id = 1'b1; end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0; ex_busy = 1'b0; ex_br_taken = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; ex_br_target = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ex_br_taken = 1'b1; ex_br_target = 64'hDEAD_BEEF_0000_0100;
    mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({dut_ctrl, pc_target, dut_cnts} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got ctrl=%b target=%h cnts=%h want all zero",
                 i, dut_ctrl, pc_target, dut_cnts);
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({pc_we, v_id, v_wb} !== {1'b1, k >= 1, k >= 4}) begin
        miscompares++;
        $display("FAIL reset_release clk=%0d got pc_we/v_id/v_wb=%b%b%b want %b%b%b",
                 k, pc_we, v_id, v_wb, 1'b1, k >= 1, k >= 4);
      end
      tick();
    end
  endtask

  task automatic test_loaduse();
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    @(negedge clk);
    vectors++;
    if ({pc_we, ifid_we, idex_bubble} !== 3'b001) begin
      miscompares++;
      $display("FAIL loaduse_stall got pc_we/ifid_we/idex_bubble=%b want 001", {pc_we, ifid_we, idex_bubble});
    end
    tick();
    // The stale load fields remain but EX now holds a bubble, so no second stall.
    @(negedge clk);
    vectors++;
    if ({pc_we, idex_bubble, v_ex} !== 3'b100) begin
      miscompares++;
      $display("FAIL loaduse_once got pc_we/idex_bubble/v_ex=%b want 100", {pc_we, idex_bubble, v_ex});
    end
    tick();
    clear_inputs();
    ex_rs1 = 5'd5; ex_rs2 = 5'd7; wb_rd = 5'd5; wb_regwrite = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1;
    @(negedge clk);
    vectors++;
    if ({v_mem, v_wb, fwd_a, fwd_b} !== 6'b010100) begin
      miscompares++;
      $display("FAIL loaduse_fwd got v_mem/v_wb/fwd_a/fwd_b=%b want 010100", {v_mem, v_wb, fwd_a, fwd_b});
    end
    tick();
  endtask

  task automatic test_forward();
    clear_inputs();
    tick();
    mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd5;
    @(negedge clk);
    vectors++;
    if ({pc_we, fwd_a, fwd_b} !== 5'b11010) begin
      miscompares++;
      $display("FAIL fwd_mem_both got pc_we/fwd_a/fwd_b=%b want 11010", {pc_we, fwd_a, fwd_b});
    end
    ex_rs2 = 5'd6; wb_rd = 5'd6;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b1001) begin
      miscompares++;
      $display("FAIL fwd_mem_wb got fwd_a/fwd_b=%b want 1001", {fwd_a, fwd_b});
    end
    mem_regwrite = 1'b0;
    #1;
    vectors++;
    if ({fwd_a, fwd_b} !== 4'b0001) begin
      miscompares++;
      $display("FAIL fwd_no_regwrite got fwd_a/fwd_b=%b want 0001", {fwd_a, fwd_b});
    end
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    vectors++;
    if ({fwd_a, fwd_b, pc_we, idex_bubble} !== 6'b000010) begin
      miscompares++;
      $display("FAIL x0_no_hazard got fwd_a/fwd_b/pc_we/idex_bubble=%b want 000010",
               {fwd_a, fwd_b, pc_we, idex_bubble});
    end
    tick();
  endtask

  task automatic test_redirect();
    clear_inputs();
    ex_br_taken = 1'b1; ex_br_target = 64'h100;
    @(negedge clk);
    vectors++;
    if ({pc_we, pc_sel, ifid_flush, idex_bubble} !== 4'b1111 || pc_target !== 64'h100) begin
      miscompares++;
      $display("FAIL redirect got pc_we/pc_sel/flush/bubble=%b target=%h want 1111 100",
               {pc_we, pc_sel, ifid_flush, idex_bubble}, pc_target);
    end
    tick();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({v_id, v_ex, pc_sel} !== {k >= 2, k >= 3, 1'b0}) begin
        miscompares++;
        $display("FAIL redirect_penalty clk=%0d got v_id/v_ex/pc_sel=%b want %b",
                 k, {v_id, v_ex, pc_sel}, {k >= 2, k >= 3, 1'b0});
      end
      tick();
      ex_br_taken = 1'b0;
    end
  endtask

  task automatic test_busy();
    int bubbles = 0;
    clear_inputs();
    ex_busy = 1'b1; ex_br_taken = 1'b1; ex_br_target = 64'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bubbles += int'(exmem_bubble);
      vectors++;
      if ({pc_we, pc_sel, ifid_flush, ifid_we, v_id, v_ex} !== 6'b000011 ||
          (k > 0 && v_mem !== 1'b0)) begin
        miscompares++;
        $display("FAIL busy_hold clk=%0d got pc_we/pc_sel/flush/ifid_we/v_id/v_ex=%b v_mem=%b want 000011",
                 k, {pc_we, pc_sel, ifid_flush, ifid_we, v_id, v_ex}, v_mem);
      end
      tick();
    end
    vectors++;
    if (bubbles !== 3) begin
      miscompares++;
      $display("FAIL busy_bubbles got %0d want 3", bubbles);
    end
    ex_busy = 1'b0;
    @(negedge clk);
    vectors++;
    if ({pc_sel, ifid_flush} !== 2'b11) begin
      miscompares++;
      $display("FAIL busy_then_redirect got pc_sel/flush=%b want 11", {pc_sel, ifid_flush});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    tick();
    tick();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    @(negedge clk);
    vectors++;
    if (idex_bubble !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_loaduse got idex_bubble=%b want 1", idex_bubble);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({dut_ctrl, pc_target, dut_cnts} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got ctrl=%b cnts=%h want zero", dut_ctrl, dut_cnts);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({v_id, v_ex, v_mem, v_wb, pc_we, idex_bubble} !== 6'b000010 || dut_cnts !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_cleared got v/pc_we/bubble=%b cnts=%h want 000010 0",
               {v_id, v_ex, v_mem, v_wb, pc_we, idex_bubble}, dut_cnts);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      id_rs1 = REG_AW'($urandom_range(0, 3)); id_rs2 = REG_AW'($urandom_range(0, 3));
      ex_rs1 = REG_AW'($urandom_range(0, 3)); ex_rs2 = REG_AW'($urandom_range(0, 3));
      ex_rd  = REG_AW'($urandom_range(0, 3)); mem_rd = REG_AW'($urandom_range(0, 3));
      wb_rd  = REG_AW'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1) == 1; id_use_rs2 = $urandom_range(0, 1) == 1;
      ex_memread = $urandom_range(0, 2) == 0; ex_busy = $urandom_range(0, 3) == 0;
      ex_br_taken = $urandom_range(0, 3) == 0;
      mem_regwrite = $urandom_range(0, 3) != 0; wb_regwrite = $urandom_range(0, 3) != 0;
      ex_br_target = {$urandom, $urandom};
      @(negedge clk);
      vectors++;
      if (dut_ctrl !== m_ctrl()) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc=%0d got %b want %b", c, dut_ctrl, m_ctrl());
      end
      vectors++;
      if (pc_target !== (reset ? 64'd0 : ex_br_target)) begin
        miscompares++;
        $display("FAIL rand_target cyc=%0d got %h want %h", c, pc_target, reset ? 64'd0 : ex_br_target);
      end
      vectors++;
      if (dut_cnts !== m_cnts()) begin
        miscompares++;
        $display("FAIL rand_counters cyc=%0d got %h want %h", c, dut_cnts, m_cnts());
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_loaduse();
    test_forward();
    test_redirect();
    test_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
